// File: rtl/adder_unit_if.sv
// Operand/result bundle for adder_unit: the master drives operands, the slave
// (the adder) returns the registered sum and status flags.
interface adder_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] r;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, cin, a, b,
    input  out_valid, r, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, cin, a, b,
    output out_valid, r, cout, ovf, zero, neg
  );
endinterface

// File: rtl/adder_unit.sv
// Two-operand adder with carry-in built from 4-bit carry-lookahead groups and a
// group-level lookahead unit; sum and ALU status flags are registered once.
module adder_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  adder_unit_if.slave  bus
);
  localparam int unsigned NGRP = WIDTH / GROUP;
  localparam int unsigned IW   = $clog2(WIDTH);

  // Flat lookahead: carry into position n = OR_j (g_j & p_{j+1..n-1}) | (p_{0..n-1} & c0).
  function automatic logic flat_carry(input logic [WIDTH-1:0] g,
                                      input logic [WIDTH-1:0] p,
                                      input logic             c0,
                                      input int unsigned      n);
    logic carry;
    logic term;
    term = c0;
    for (int unsigned m = 0; m < n; m++) term = term & p[IW'(m)];
    carry = term;
    for (int unsigned j = 0; j < n; j++) begin
      term = g[IW'(j)];
      for (int unsigned m = j + 1; m < n; m++) term = term & p[IW'(m)];
      carry = carry | term;
    end
    return carry;
  endfunction

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP:0]    grp_c;

  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             zero_d;
  logic             neg_d;

  logic             valid_q;
  logic [WIDTH-1:0] r_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;

  always_comb begin
    g = bus.a & bus.b;
    p = bus.a ^ bus.b;
  end

  for (genvar k = 0; k < NGRP; k++) begin : g_grp
    assign grp_g[k] = flat_carry(WIDTH'(g[k*GROUP +: GROUP]), WIDTH'(p[k*GROUP +: GROUP]), 1'b0, GROUP);
    assign grp_p[k] = &p[k*GROUP +: GROUP];
    for (genvar i = 0; i < GROUP; i++) begin : g_bit
      assign c[k*GROUP+i] = flat_carry(WIDTH'(g[k*GROUP +: GROUP]), WIDTH'(p[k*GROUP +: GROUP]),
                                       grp_c[k], i);
    end
  end

  for (genvar k = 0; k <= NGRP; k++) begin : g_gcarry
    assign grp_c[k] = flat_carry(WIDTH'(grp_g), WIDTH'(grp_p), bus.cin, k);
  end

  always_comb begin
    sum_d  = p ^ c;
    cout_d = grp_c[NGRP];
    ovf_d  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum_d[WIDTH-1] != bus.a[WIDTH-1]);
    zero_d = ~|sum_d;
    neg_d  = sum_d[WIDTH-1];
  end

  // Result fields update only on accepted operands so idle-cycle inputs never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      r_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        r_q    <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= zero_d;
        neg_q  <= neg_d;
      end
    end
  end

  always_comb begin
    bus.out_valid = valid_q;
    bus.r         = r_q;
    bus.cout      = cout_q;
    bus.ovf       = ovf_q;
    bus.zero      = zero_q;
    bus.neg       = neg_q;
  end
endmodule

// File: tb/tb_adder_unit.sv
// Scoreboard bench for adder_unit: directed vectors queue expected results,
// a negedge monitor pops and compares whenever out_valid is seen.
module tb_adder_unit;
  typedef struct packed {
    logic        cout;
    logic [15:0] r;
    logic        ovf;
    logic        zero;
    logic        neg;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  adder_unit_if #(.WIDTH(16)) bus ();

  adder_unit #(.WIDTH(16), .GROUP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic c, input logic [15:0] r, input logic o,
                              input logic z, input logic n);
    exp_t e;
    e.cout = c; e.r = r; e.ovf = o; e.zero = z; e.neg = n;
    return e;
  endfunction

  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input logic ci);
    logic [16:0] s;
    s = {1'b0, av} + {1'b0, bv} + {16'd0, ci};
    return mk(s[16], s[15:0], (av[15] == bv[15]) && (s[15] != av[15]), s[15:0] == 16'd0, s[15]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {12'd0, bus.out_valid, bus.cout, bus.r, bus.ovf, bus.zero, bus.neg};
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", {12'd0, e}, {12'd0, bus.cout, bus.r, bus.ovf, bus.zero, bus.neg});
      end
    end
  end

  task automatic drive(input logic [15:0] av, input logic [15:0] bv, input logic ci, input exp_t e);
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.a = av; bus.b = bv; bus.cin = ci;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.a = 16'hDEAD; bus.b = 16'hBEEF; bus.cin = 1'b1;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    #1 rst_n = 1'b0;
    #49 chk("reset_outputs", outs(), 32'd0);
    #50 rst_n = 1'b1;

    drive(16'd100,  16'd20,   1'b0, mk(1'b0, 16'd120,  1'b0, 1'b0, 1'b0));
    drive(16'hFFFF, 16'h0000, 1'b1, mk(1'b1, 16'h0000, 1'b0, 1'b1, 1'b0));
    drive(16'h7FFF, 16'h0001, 1'b0, mk(1'b0, 16'h8000, 1'b1, 1'b0, 1'b1));
    drive(16'h8000, 16'h8000, 1'b0, mk(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0));
    drive(16'hFFFF, 16'hFFFF, 1'b1, mk(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1));
    drive(16'h0FFF, 16'h0001, 1'b0, mk(1'b0, 16'h1000, 1'b0, 1'b0, 1'b0));
    idle();
    idle();

    // Three back-to-back operands, then a hold with junk inputs.
    drive(16'h1234, 16'h4321, 1'b0, mk(1'b0, 16'h5555, 1'b0, 1'b0, 1'b0));
    drive(16'h00FF, 16'h0F01, 1'b1, mk(1'b0, 16'h1001, 1'b0, 1'b0, 1'b0));
    drive(16'hA000, 16'h9000, 1'b0, mk(1'b1, 16'h3000, 1'b1, 1'b0, 1'b0));
    idle();
    @(posedge clk); #2;
    chk("hold_cycle1", outs(), {12'd0, 1'b0, 1'b1, 16'h3000, 1'b1, 1'b0, 1'b0});
    @(posedge clk); #2;
    chk("hold_cycle2", outs(), {12'd0, 1'b0, 1'b1, 16'h3000, 1'b1, 1'b0, 1'b0});
    chk("queue_drained_directed", sb.size(), 32'd0);

    // Asynchronous reset mid-cycle with an operand in flight.
    drive(16'h1111, 16'h2222, 1'b0, mk(1'b0, 16'h3333, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #3;
    rst_n = 1'b0;
    sb.delete();
    #1 chk("async_reset_midcycle", outs(), 32'd0);
    @(posedge clk); #2;
    chk("reset_held_in_valid", outs(), 32'd0);
    bus.in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #2;
    chk("no_stale_valid", outs(), 32'd0);
    @(posedge clk); #2;
    chk("no_stale_valid2", outs(), 32'd0);

    // Random sweep against {cout,r} = a + b + cin.
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] av, bv;
      logic        ci;
      av = 16'($urandom); bv = 16'($urandom); ci = 1'($urandom);
      if ($urandom_range(0, 7) != 0) begin
        drive(av, bv, ci, model(av, bv, ci));
      end else begin
        idle();
      end
    end
    idle();
    repeat (3) @(posedge clk);
    #2 chk("queue_drained_sweep", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
